// File: rtl/iter_mdu.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiply-class ops run a fixed countdown of MUL_LAT cycles and commit the
// full double-width result at the end; divides run WIDTH restoring-division
// iterations on magnitudes followed by one sign-fix/commit cycle.
//
// Handshake: start is a one-cycle issue strobe sampled on a rising edge; it is
// only accepted while busy=0 (otherwise dropped without effect), and done
// pulses for exactly one cycle after HI/LO are written. flush aborts the
// current operation and blocks any start presented on the same edge.
module iter_mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam int CW = 7;
  // Countdown starts at L-1 so the commit lands exactly L edges after issue.
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  // Multiply datapath (operands are latched, HI/LO cannot change while busy).
  logic                 w_mul_signed;
  logic [2*WIDTH-1:0]   w_a_ext;
  logic [2*WIDTH-1:0]   w_b_ext;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_acc;
  logic [2*WIDTH-1:0]   w_mul_res;

  // Divide datapath.
  logic                 w_in_signed;
  logic                 w_d1_neg;
  logic                 w_d2_neg;
  logic [WIDTH-1:0]     w_d1_abs;
  logic [WIDTH-1:0]     w_d2_abs;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH-1:0]     w_trial;
  logic                 w_fits;
  logic [WIDTH-1:0]     w_q_fix;
  logic [WIDTH-1:0]     w_r_fix;

  assign w_mul_signed = ~r_op[0];
  assign w_a_ext = w_mul_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_b_ext = w_mul_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_acc   = {r_hi, r_lo};

  // Select plain product, accumulate or subtract according to the op class.
  always_comb begin
    w_mul_res = w_prod;
    case (r_op[2:1])
      2'b10:   w_mul_res = w_acc + w_prod;
      2'b11:   w_mul_res = w_acc - w_prod;
      default: w_mul_res = w_prod;
    endcase
  end

  // Divide works on magnitudes; the signs are reapplied in the final cycle.
  assign w_in_signed = ~op[0];
  assign w_d1_neg    = w_in_signed & d1[WIDTH-1];
  assign w_d2_neg    = w_in_signed & d2[WIDTH-1];
  assign w_d1_abs    = w_d1_neg ? -d1 : d1;
  assign w_d2_abs    = w_d2_neg ? -d2 : d2;

  // One restoring step: shift the next dividend bit into the remainder.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_fits  = (w_shift >= {1'b0, r_dvs});
  assign w_trial = w_shift[WIDTH-1:0] - r_dvs;
  assign w_q_fix = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  // Main FSM: issue decode, multiply countdown, divide iterations and commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        // Abort: drop whatever is in flight and refuse a same-edge issue.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              case (op)
                4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
                  r_state <= S_MUL;
                  r_busy  <= 1'b1;
                  r_cnt   <= MUL_CNT;
                  r_op    <= op;
                  r_a     <= d1;
                  r_b     <= d2;
                end
                4'd2, 4'd3: begin
                  r_state <= S_DIV;
                  r_busy  <= 1'b1;
                  r_cnt   <= DIV_CNT;
                  r_op    <= op;
                  r_a     <= d1;
                  r_b     <= d2;
                  r_rem   <= '0;
                  r_quo   <= w_d1_abs;
                  r_dvs   <= w_d2_abs;
                  r_neg_q <= w_d1_neg ^ w_d2_neg;
                  r_neg_r <= w_d1_neg;
                  r_dz    <= (d2 == '0);
                end
                4'd8:    r_hi <= d1;
                4'd9:    r_lo <= d1;
                default: ;
              endcase
            end
          end
          S_MUL: begin
            if (r_cnt == '0) begin
              {r_hi, r_lo} <= w_mul_res;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_DIV: begin
            if (r_cnt == '0) begin
              // Sign-fix cycle; divide by zero returns all-ones / dividend.
              if (r_dz) begin
                r_lo <= '1;
                r_hi <= r_a;
              end else begin
                r_lo <= w_q_fix;
                r_hi <= w_r_fix;
              end
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_rem <= w_fits ? w_trial : w_shift[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], w_fits};
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule
